// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serializer.
package piso_pkg;

  localparam int unsigned PISO_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } piso_state_e;

endpackage : piso_pkg

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer: counts 0..WIDTH-1 and never wraps.
// Flags the last bit and the bit before it so the top can register `done`.
module piso_bit_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o,
  output logic penult_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign last_o   = (cnt_q == CNT_W'(WIDTH - 1));
  assign penult_o = (cnt_q == CNT_W'(WIDTH - 2));

  // Clear has priority; increment saturates at the last bit position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !last_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule : piso_bit_counter

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shift register, MSB first, valid/ready load side.
// Optional trailing even-parity bit when PISO_PARITY_EN is defined; without it
// a new word may be loaded on the last data bit for gapless back-to-back output.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = PISO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  output logic             shift_out_o,
  output logic             shift_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             cnt_clr, cnt_en, cnt_last, cnt_penult;
  logic             shift_out_q, shift_out_d;
  logic             shift_valid_q, shift_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  piso_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .last_o   (cnt_last),
    .penult_o (cnt_penult)
  );

  // Next-state, shift register and load_ready decode.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    load_ready_o = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        load_ready_o = 1'b1;
        if (load_valid_i) begin
          shreg_d = load_data_i;
          cnt_clr = 1'b1;
          state_d = ST_SHIFT;
`ifdef PISO_PARITY_EN
          parity_d = ^load_data_i;
`endif
        end
      end
      ST_SHIFT: begin
        shreg_d = shreg_q << 1;
        if (cnt_last) begin
          cnt_clr = 1'b1;
`ifdef PISO_PARITY_EN
          state_d = ST_PARITY;
`else
          load_ready_o = 1'b1;
          if (load_valid_i) begin
            shreg_d = load_data_i;
          end else begin
            state_d = ST_IDLE;
          end
`endif
        end else begin
          cnt_en = 1'b1;
        end
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state so the
  // first bit appears in the cycle right after the accept edge.
  always_comb begin
    shift_out_d   = 1'b0;
    shift_valid_d = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    case (state_d)
      ST_SHIFT: begin
        shift_out_d   = shreg_d[WIDTH-1];
        shift_valid_d = 1'b1;
        busy_d        = 1'b1;
`ifndef PISO_PARITY_EN
        done_d        = (state_q == ST_SHIFT) && cnt_penult;
`endif
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        shift_out_d   = parity_q;
        shift_valid_d = 1'b1;
        busy_d        = 1'b1;
        done_d        = 1'b1;
      end
`endif
      default: begin
        shift_out_d = 1'b0;
      end
    endcase
  end

  // State, data and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      shift_out_q   <= 1'b0;
      shift_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      shift_out_q   <= shift_out_d;
      shift_valid_q <= shift_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

`ifdef PISO_PARITY_EN
  // Parity of the accepted word, held until its parity cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign shift_out_o   = shift_out_q;
  assign shift_valid_o = shift_valid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule : piso_serializer
